alu_muldiv_seq: RTL and testbench

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 77 +++++++
 rtl/alu_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SLTU  = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_MULT  = 4'd8;
   localparam logic [3:0] OP_MULTU = 4'd9;
   localparam logic [3:0] OP_DIV   = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;
   localparam logic [3:0] OP_NOR   = 4'd12;
   localparam logic [3:0] OP_MFHI  = 4'd13;
   localparam logic [3:0] OP_MFLO  = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Opcodes 8..11: bit1 selects divide, bit0 selects unsigned.
   function automatic logic is_muldiv_op(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle for WIDTH cycles, with sign fix-up on the outputs.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
   logic               div_q, neg_q, neg_r;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_sh, div_trial;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
   assign div_trial = div_sh - {1'b0, opnd};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (start) begin
         cnt    <= CW'(WIDTH);
         acc_hi <= '0;
         acc_lo <= op ? mag_a : mag_b;
         opnd   <= op ? mag_b : mag_a;
         div_q  <= op;
         neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r  <= is_signed && a[WIDTH-1];
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         if (div_q) begin
            // Restoring step: keep the trial remainder only if it did not go negative.
            if (!div_trial[WIDTH]) begin
               acc_hi <= div_trial[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= div_sh[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // High during the cycle whose closing edge performs the final iteration.
   assign done = (cnt == CW'(1));

   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign res_hi   = div_q ? (neg_r ? -acc_hi : acc_hi) : prod_fix[2*WIDTH-1:WIDTH];
   assign res_lo   = div_q ? (neg_q ? -acc_lo : acc_lo) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus an iterative mul/div
// engine that writes the HI/LO architectural registers.
//
// state   | meaning
// IDLE    | accepting requests; single-cycle ops complete here
// BUSY    | mul/div engine iterating, requests ignored
// DONE    | commit HI/LO and pulse OutValid, then back to IDLE
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MULDIV_EN = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] ALUResult,
   output logic             OutValid,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   state_t           state, state_nxt;
   logic             accept, is_md, start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [WIDTH-1:0] sum, diff, alu_res;
   logic             alu_ovf;
   logic             md_div, md_divzero;
   logic [WIDTH-1:0] md_dividend, md_hi, md_lo;

   assign InReady = (state == ST_IDLE);
   assign accept  = InValid && InReady;
   assign is_md   = (MULDIV_EN != 0) && is_muldiv_op(ALUControl);

   generate
      if (MULDIV_EN != 0) begin : g_md
         alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
            .Clk       (Clk),
            .Reset     (Reset),
            .start     (start),
            .is_signed (~ALUControl[0]),
            .op        (ALUControl[1]),
            .a         (A),
            .b         (B),
            .done      (iter_done),
            .res_hi    (iter_hi),
            .res_lo    (iter_lo)
         );
      end else begin : g_no_md
         assign iter_done = 1'b0;
         assign iter_hi   = '0;
         assign iter_lo   = '0;
      end
   endgenerate

   // Divide by zero bypasses the engine result entirely.
   assign md_hi = (md_div && md_divzero) ? md_dividend : iter_hi;
   assign md_lo = (md_div && md_divzero) ? '1 : iter_lo;

   assign sum  = A + B;
   assign diff = A - B;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ALUControl)
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_NOR:  alu_res = ~(A | B);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
         OP_SLTU: alu_res = WIDTH'(A < B);
         OP_MFHI: alu_res = HI;
         OP_MFLO: alu_res = LO;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && is_md) begin
               state_nxt = ST_BUSY;
               start     = 1'b1;
            end
         end
         ST_BUSY: if (iter_done) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ALUResult   <= '0;
         OutValid    <= 1'b0;
         Zero        <= 1'b0;
         Overflow    <= 1'b0;
         DivZero     <= 1'b0;
         HI          <= '0;
         LO          <= '0;
         md_div      <= 1'b0;
         md_divzero  <= 1'b0;
         md_dividend <= '0;
      end else begin
         OutValid <= 1'b0;
         if (state == ST_DONE) begin
            HI        <= md_hi;
            LO        <= md_lo;
            ALUResult <= md_lo;
            Zero      <= (md_lo == '0);
            Overflow  <= 1'b0;
            DivZero   <= md_div && md_divzero;
            OutValid  <= 1'b1;
         end else if (accept) begin
            if (is_md) begin
               md_div      <= ALUControl[1];
               md_divzero  <= (B == '0);
               md_dividend <= A;
            end else begin
               ALUResult <= alu_res;
               Zero      <= (alu_res == '0);
               Overflow  <= alu_ovf;
               DivZero   <= 1'b0;
               OutValid  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at WIDTH=32, WIDTH=16 and with the
// mul/div engine removed.
module tb_alu_muldiv_seq;

   logic Clk;
   logic Reset;
   int   checks;
   int   failures;

   logic [3:0]  op32, op16, op0;
   logic [31:0] a32, b32, a0, b0;
   logic [15:0] a16, b16;
   logic        iv32, iv16, iv0;
   logic        ir32, ir16, ir0;
   logic [31:0] res32, hi32, lo32, res0, hi0, lo0;
   logic [15:0] res16, hi16, lo16;
   logic        val32, zero32, ovf32, dz32;
   logic        val16, zero16, ovf16, dz16;
   logic        val0, zero0, ovf0, dz0;

   alu_muldiv_seq #(.WIDTH(32), .MULDIV_EN(1)) u32 (
      .Clk(Clk), .Reset(Reset), .ALUControl(op32), .A(a32), .B(b32),
      .InValid(iv32), .InReady(ir32), .ALUResult(res32), .OutValid(val32),
      .Zero(zero32), .Overflow(ovf32), .DivZero(dz32), .HI(hi32), .LO(lo32));

   alu_muldiv_seq #(.WIDTH(16), .MULDIV_EN(1)) u16 (
      .Clk(Clk), .Reset(Reset), .ALUControl(op16), .A(a16), .B(b16),
      .InValid(iv16), .InReady(ir16), .ALUResult(res16), .OutValid(val16),
      .Zero(zero16), .Overflow(ovf16), .DivZero(dz16), .HI(hi16), .LO(lo16));

   alu_muldiv_seq #(.WIDTH(32), .MULDIV_EN(0)) u0 (
      .Clk(Clk), .Reset(Reset), .ALUControl(op0), .A(a0), .B(b0),
      .InValid(iv0), .InReady(ir0), .ALUResult(res0), .OutValid(val0),
      .Zero(zero0), .Overflow(ovf0), .DivZero(dz0), .HI(hi0), .LO(lo0));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        ovf;
   } vec_t;

   localparam int NVEC = 16;
   localparam vec_t VECS [NVEC] = '{
      '{4'd2,  32'd12,        32'd12,        32'd24,        1'b0},
      '{4'd6,  32'd12,        32'd12,        32'd0,         1'b0},
      '{4'd7,  32'd11,        32'd56,        32'd1,         1'b0},
      '{4'd7,  32'd100,       32'd56,        32'd0,         1'b0},
      '{4'd12, 32'd100,       32'd56,        32'hFFFFFF83,  1'b0},
      '{4'd2,  32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b1},
      '{4'd6,  32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1},
      '{4'd3,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0},
      '{4'd7,  32'hFFFFFFFF,  32'd1,         32'd1,         1'b0},
      '{4'd0,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0},
      '{4'd1,  32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  1'b0},
      '{4'd4,  32'hFFFF0000,  32'hFF00FF00,  32'h00FFFF00,  1'b0},
      '{4'd5,  32'd1,         32'd2,         32'd0,         1'b0},
      '{4'd15, 32'd9,         32'd9,         32'd0,         1'b0},
      '{4'd6,  32'd5,         32'd7,         32'hFFFFFFFE,  1'b0},
      '{4'd2,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0}
   };

   task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
      @(posedge Clk); #1;
      iv32 = 1'b0;
   endtask

   task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge Clk);
      op16 = op; a16 = a; b16 = b; iv16 = 1'b1;
      @(posedge Clk); #1;
      iv16 = 1'b0;
   endtask

   task automatic issue0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      op0 = op; a0 = a; b0 = b; iv0 = 1'b1;
      @(posedge Clk); #1;
      iv0 = 1'b0;
   endtask

   // Advance to just after the commit edge of a mul/div accepted by issue32.
   task automatic wait_md32();
      repeat (33) @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (res32 !== 32'd0 || val32 !== 1'b0 || zero32 !== 1'b0 || ovf32 !== 1'b0 ||
          dz32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs res=%h val=%b zero=%b ovf=%b dz=%b hi=%h lo=%h want all zero",
                  res32, val32, zero32, ovf32, dz32, hi32, lo32);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      #1;
      checks++;
      if (ir32 !== 1'b1 || ir16 !== 1'b1 || ir0 !== 1'b1) begin
         failures++;
         $display("FAIL reset_inready got %b%b%b want 111", ir32, ir16, ir0);
      end
   endtask

   task automatic test_single_cycle();
      for (int i = 0; i < NVEC; i++) begin
         issue32(VECS[i].op, VECS[i].a, VECS[i].b);
         checks++;
         if (val32 !== 1'b1 || res32 !== VECS[i].r || zero32 !== (VECS[i].r == 32'd0) ||
             ovf32 !== VECS[i].ovf || dz32 !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle[%0d] op=%0d val=%b res=%h zero=%b ovf=%b dz=%b want val=1 res=%h ovf=%b dz=0",
                     i, VECS[i].op, val32, res32, zero32, ovf32, dz32, VECS[i].r, VECS[i].ovf);
         end
      end
      @(posedge Clk); #1;
      checks++;
      if (val32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
         failures++;
         $display("FAIL single_cycle_idle val=%b hi=%h lo=%h want 0/0/0", val32, hi32, lo32);
      end
   endtask

   task automatic test_back_to_back();
      issue32(4'd2, 32'd1, 32'd2);
      checks++;
      if (val32 !== 1'b1 || res32 !== 32'd3) begin
         failures++;
         $display("FAIL b2b_first val=%b res=%h want 1/3", val32, res32);
      end
      issue32(4'd6, 32'd10, 32'd3);
      checks++;
      if (val32 !== 1'b1 || res32 !== 32'd7) begin
         failures++;
         $display("FAIL b2b_second val=%b res=%h want 1/7", val32, res32);
      end
   endtask

   task automatic test_mult();
      int busy_bad;
      issue32(4'd8, 32'hFFFFFFFD, 32'd7);
      checks++;
      if (ir32 !== 1'b0 || val32 !== 1'b0) begin
         failures++;
         $display("FAIL mult_accept ir=%b val=%b want 0/0", ir32, val32);
      end
      op32 = 4'd2; a32 = 32'd1; b32 = 32'd1; iv32 = 1'b1;
      busy_bad = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge Clk); #1;
         if (val32 !== 1'b0 || ir32 !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL mult_busy violations=%0d want 0", busy_bad);
      end
      @(posedge Clk); #1;
      iv32 = 1'b0;
      checks++;
      if (val32 !== 1'b1 || hi32 !== 32'hFFFFFFFF || lo32 !== 32'hFFFFFFEB ||
          res32 !== 32'hFFFFFFEB || dz32 !== 1'b0 || zero32 !== 1'b0) begin
         failures++;
         $display("FAIL mult_result val=%b hi=%h lo=%h res=%h dz=%b zero=%b want 1/ffffffff/ffffffeb/ffffffeb/0/0",
                  val32, hi32, lo32, res32, dz32, zero32);
      end
      checks++;
      if (ir32 !== 1'b1) begin
         failures++;
         $display("FAIL mult_ready_after ir=%b want 1", ir32);
      end
      issue32(4'd14, 32'd0, 32'd0);
      checks++;
      if (res32 !== 32'hFFFFFFEB || val32 !== 1'b1) begin
         failures++;
         $display("FAIL mflo res=%h val=%b want ffffffeb/1", res32, val32);
      end
      issue32(4'd13, 32'd0, 32'd0);
      checks++;
      if (res32 !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL mfhi_mult res=%h want ffffffff", res32);
      end
      issue32(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_md32();
      checks++;
      if (val32 !== 1'b1 || hi32 !== 32'hFFFFFFFE || lo32 !== 32'h00000001) begin
         failures++;
         $display("FAIL multu_max val=%b hi=%h lo=%h want 1/fffffffe/00000001", val32, hi32, lo32);
      end
   endtask

   task automatic test_divide();
      issue32(4'd10, 32'hFFFFFF9C, 32'd7);
      wait_md32();
      checks++;
      if (val32 !== 1'b1 || lo32 !== 32'hFFFFFFF2 || hi32 !== 32'hFFFFFFFE ||
          res32 !== 32'hFFFFFFF2 || dz32 !== 1'b0) begin
         failures++;
         $display("FAIL div_neg val=%b lo=%h hi=%h res=%h dz=%b want 1/fffffff2/fffffffe/fffffff2/0",
                  val32, lo32, hi32, res32, dz32);
      end
      issue32(4'd13, 32'd0, 32'd0);
      checks++;
      if (res32 !== 32'hFFFFFFFE) begin
         failures++;
         $display("FAIL mfhi_div res=%h want fffffffe", res32);
      end
      issue32(4'd11, 32'd100, 32'd0);
      wait_md32();
      checks++;
      if (val32 !== 1'b1 || lo32 !== 32'hFFFFFFFF || hi32 !== 32'd100 || dz32 !== 1'b1) begin
         failures++;
         $display("FAIL divu_zero val=%b lo=%h hi=%h dz=%b want 1/ffffffff/00000064/1", val32, lo32, hi32, dz32);
      end
      issue32(4'd13, 32'd0, 32'd0);
      checks++;
      if (res32 !== 32'd100 || dz32 !== 1'b0) begin
         failures++;
         $display("FAIL mfhi_divzero res=%h dz=%b want 00000064/0", res32, dz32);
      end
      issue32(4'd10, 32'h80000000, 32'hFFFFFFFF);
      wait_md32();
      checks++;
      if (val32 !== 1'b1 || lo32 !== 32'h80000000 || hi32 !== 32'd0 || dz32 !== 1'b0) begin
         failures++;
         $display("FAIL div_minneg val=%b lo=%h hi=%h dz=%b want 1/80000000/0/0", val32, lo32, hi32, dz32);
      end
      issue32(4'd11, 32'd100, 32'd7);
      wait_md32();
      checks++;
      if (lo32 !== 32'd14 || hi32 !== 32'd2) begin
         failures++;
         $display("FAIL divu lo=%h hi=%h want 0000000e/00000002", lo32, hi32);
      end
      issue32(4'd2, 32'd3, 32'd4);
      checks++;
      if (res32 !== 32'd7 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
         failures++;
         $display("FAIL hilo_preserved res=%h lo=%h hi=%h want 7/e/2", res32, lo32, hi32);
      end
   endtask

   task automatic test_reset_abort();
      int pulses;
      issue32(4'd9, 32'd5, 32'd6);
      repeat (9) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      checks++;
      if (hi32 !== 32'd0 || lo32 !== 32'd0 || val32 !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset hi=%h lo=%h val=%b want 0/0/0", hi32, lo32, val32);
      end
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      checks++;
      if (ir32 !== 1'b1) begin
         failures++;
         $display("FAIL abort_ready ir=%b want 1", ir32);
      end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         if (val32 !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
         failures++;
         $display("FAIL abort_no_commit pulses=%0d hi=%h lo=%h want 0/0/0", pulses, hi32, lo32);
      end
   endtask

   task automatic test_width16();
      int busy_bad;
      issue16(4'd2, 16'd12, 16'd12);
      checks++;
      if (val16 !== 1'b1 || res16 !== 16'd24 || zero16 !== 1'b0) begin
         failures++;
         $display("FAIL w16_add val=%b res=%h zero=%b want 1/0018/0", val16, res16, zero16);
      end
      issue16(4'd6, 16'd12, 16'd12);
      checks++;
      if (val16 !== 1'b1 || res16 !== 16'd0 || zero16 !== 1'b1) begin
         failures++;
         $display("FAIL w16_sub val=%b res=%h zero=%b want 1/0000/1", val16, res16, zero16);
      end
      issue16(4'd8, 16'hFFFD, 16'd7);
      busy_bad = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge Clk); #1;
         if (val16 !== 1'b0 || ir16 !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL w16_busy violations=%0d want 0", busy_bad);
      end
      @(posedge Clk); #1;
      checks++;
      if (val16 !== 1'b1 || hi16 !== 16'hFFFF || lo16 !== 16'hFFEB || res16 !== 16'hFFEB) begin
         failures++;
         $display("FAIL w16_mult val=%b hi=%h lo=%h res=%h want 1/ffff/ffeb/ffeb", val16, hi16, lo16, res16);
      end
   endtask

   task automatic test_no_muldiv();
      issue0(4'd2, 32'd12, 32'd12);
      checks++;
      if (val0 !== 1'b1 || res0 !== 32'd24 || zero0 !== 1'b0) begin
         failures++;
         $display("FAIL nomd_add val=%b res=%h zero=%b want 1/18/0", val0, res0, zero0);
      end
      issue0(4'd6, 32'd12, 32'd12);
      checks++;
      if (val0 !== 1'b1 || res0 !== 32'd0 || zero0 !== 1'b1) begin
         failures++;
         $display("FAIL nomd_sub val=%b res=%h zero=%b want 1/0/1", val0, res0, zero0);
      end
      issue0(4'd8, 32'hFFFFFFFD, 32'd7);
      checks++;
      if (val0 !== 1'b1 || res0 !== 32'd0 || hi0 !== 32'd0 || lo0 !== 32'd0 || ir0 !== 1'b1) begin
         failures++;
         $display("FAIL nomd_mult val=%b res=%h hi=%h lo=%h ir=%b want 1/0/0/0/1", val0, res0, hi0, lo0, ir0);
      end
      issue0(4'd10, 32'd5, 32'd0);
      checks++;
      if (val0 !== 1'b1 || res0 !== 32'd0 || dz0 !== 1'b0 || zero0 !== 1'b1) begin
         failures++;
         $display("FAIL nomd_div val=%b res=%h dz=%b zero=%b want 1/0/0/1", val0, res0, dz0, zero0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      Reset = 1'b0;
      op32 = '0; a32 = '0; b32 = '0; iv32 = 1'b0;
      op16 = '0; a16 = '0; b16 = '0; iv16 = 1'b0;
      op0  = '0; a0  = '0; b0  = '0; iv0  = 1'b0;
      test_reset();
      test_single_cycle();
      test_back_to_back();
      test_mult();
      test_divide();
      test_reset_abort();
      test_width16();
      test_no_muldiv();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
